// File: rtl/mem_access_ctrl.sv
// Data-memory access controller for the shared register bus: address register, MDR and
// a fixed-latency read/write sequencer, with read data returned through a tri-state bus driver.
module mem_access_ctrl #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              RST,
    input  logic [DATA_W-1:0] BIN,
    input  logic              LDAR,
    input  logic              INC_AR,
    input  logic              RD,
    input  logic              WRM,
    input  logic              LDBUS,
    output logic [DATA_W-1:0] BOUT,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_re,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned CNT_W = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RWAIT,
        S_WWAIT
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [ADDR_W-1:0]  ar_q;
    logic [ADDR_W-1:0]  ar_d;
    logic [ADDR_W-1:0]  mem_addr_q;
    logic [DATA_W-1:0]  mdr_q;
    logic               busy_q;
    logic               done_q;
    logic               mem_re_q;
    logic               mem_we_q;

    // Candidate AR for an idle cycle; increment takes priority over load.
    always_comb begin
        ar_d = ar_q;
        if (INC_AR) begin
            ar_d = ar_q + ADDR_W'(1);
        end else if (LDAR) begin
            ar_d = BIN[ADDR_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            ar_q       <= '0;
            mem_addr_q <= '0;
            mdr_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            mem_re_q   <= 1'b0;
            mem_we_q   <= 1'b0;
        end else begin
            mem_re_q <= 1'b0;
            mem_we_q <= 1'b0;
            done_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    ar_q <= ar_d;
                    // An accepted access keeps the address AR held before this edge.
                    if (RD) begin
                        mem_re_q   <= 1'b1;
                        cnt_q      <= CNT_W'(MEM_LAT);
                        mem_addr_q <= ar_q;
                        busy_q     <= 1'b1;
                        state_q    <= S_RWAIT;
                    end else if (WRM) begin
                        mdr_q      <= BIN;
                        mem_we_q   <= 1'b1;
                        cnt_q      <= CNT_W'(MEM_LAT);
                        mem_addr_q <= ar_q;
                        busy_q     <= 1'b1;
                        state_q    <= S_WWAIT;
                    end else begin
                        mem_addr_q <= ar_d;
                    end
                end
                S_RWAIT, S_WWAIT: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else begin
                        if (state_q == S_RWAIT) begin
                            mdr_q <= mem_rdata;
                        end
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign BOUT      = LDBUS ? mdr_q : {DATA_W{1'bz}};
    assign busy      = busy_q;
    assign done      = done_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mdr_q;
    assign mem_re    = mem_re_q;
    assign mem_we    = mem_we_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Random and directed bench for mem_access_ctrl against a transaction-level reference model.
module tb_mem_access_ctrl;

    localparam int unsigned DW  = 16;
    localparam int unsigned AW  = 16;
    localparam int unsigned LAT = 2;

    logic          clk = 1'b0;
    logic          RST = 1'b1;
    logic [DW-1:0] BIN = '0;
    logic          LDAR = 1'b0, INC_AR = 1'b0, RD = 1'b0, WRM = 1'b0, LDBUS = 1'b0;
    wire  [DW-1:0] BOUT;
    logic          busy, done, mem_re, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic [DW-1:0] mem [0:65535];

    int n_vec = 0;
    int n_err = 0;

    // Reference model: AR, MDR, memory address, cycles left in the current access.
    logic [AW-1:0] m_ar, m_maddr;
    logic [DW-1:0] m_mdr;
    int            m_left;
    bit            m_read, m_re, m_we, m_done;

    mem_access_ctrl #(.DATA_W(DW), .ADDR_W(AW), .MEM_LAT(LAT)) dut (
        .clk(clk), .RST(RST), .BIN(BIN), .LDAR(LDAR), .INC_AR(INC_AR),
        .RD(RD), .WRM(WRM), .LDBUS(LDBUS), .BOUT(BOUT), .busy(busy), .done(done),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_we(mem_we),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge(input bit rst, input logic [DW-1:0] bin, input bit ldar,
                              input bit inc, input bit rd, input bit wrm);
        logic [AW-1:0] nxt;
        m_re   = 0;
        m_we   = 0;
        m_done = 0;
        if (rst) begin
            m_ar = '0; m_maddr = '0; m_mdr = '0; m_left = 0; m_read = 0;
        end else if (m_left == 0) begin
            nxt = inc ? m_ar + 16'd1 : (ldar ? bin : m_ar);
            if (rd || wrm) begin
                m_maddr = m_ar;
                m_left  = LAT + 1;
                m_read  = rd;
                if (rd) m_re = 1;
                else begin m_we = 1; m_mdr = bin; end
            end else begin
                m_maddr = nxt;
            end
            m_ar = nxt;
        end else begin
            m_left--;
            if (m_left == 0) begin
                m_done = 1;
                if (m_read) m_mdr = mem[m_maddr];
            end
        end
    endtask

    task automatic step(input bit rst, input logic [DW-1:0] bin, input bit ldar, input bit inc,
                        input bit rd, input bit wrm, input bit ldbus);
        @(negedge clk);
        RST = rst; BIN = bin; LDAR = ldar; INC_AR = inc; RD = rd; WRM = wrm; LDBUS = ldbus;
        @(posedge clk);
        model_edge(rst, bin, ldar, inc, rd, wrm);
        #1;
        chk("busy", 32'(busy), 32'(m_left != 0));
        chk("done", 32'(done), 32'(m_done));
        chk("mem_re", 32'(mem_re), 32'(m_re));
        chk("mem_we", 32'(mem_we), 32'(m_we));
        chk("mem_addr", 32'(mem_addr), 32'(m_maddr));
        chk("mem_wdata", 32'(mem_wdata), 32'(m_mdr));
        if (ldbus) chk("bout", 32'(BOUT), 32'(m_mdr));
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
        mem[16'h0040] = 16'hBEEF;
        m_ar = '0; m_maddr = '0; m_mdr = '0; m_left = 0; m_read = 0;

        // Reset after some activity
        step(1, 16'h0, 0, 0, 0, 0, 0);
        step(0, 16'h0123, 1, 0, 0, 0, 0);
        step(0, 16'h5555, 0, 0, 0, 1, 0);
        step(1, 16'h0, 0, 0, 0, 0, 1);
        chk("rst_bout", 32'(BOUT), 32'h0);
        chk("rst_addr", 32'(mem_addr), 32'h0);
        step(0, 16'h0, 0, 0, 0, 0, 0);

        // Read from 0x0040
        step(0, 16'h0040, 1, 0, 0, 0, 0);
        step(0, 16'h0000, 0, 0, 1, 0, 0);
        chk("rd_strobe", 32'(mem_re), 32'h1);
        chk("rd_addr", 32'(mem_addr), 32'h0040);
        step(0, 16'h0, 0, 0, 0, 0, 0);
        step(0, 16'h0, 0, 0, 0, 0, 1);
        step(0, 16'h0, 0, 0, 0, 0, 1);
        chk("rd_done", 32'(done), 32'h1);
        chk("rd_data", 32'(BOUT), 32'hBEEF);

        // Write to 0x0041 with an ignored RD mid-access
        step(0, 16'h0, 0, 1, 0, 0, 0);
        step(0, 16'h1234, 0, 0, 0, 1, 0);
        chk("wr_strobe", 32'(mem_we), 32'h1);
        chk("wr_addr", 32'(mem_addr), 32'h0041);
        chk("wr_data", 32'(mem_wdata), 32'h1234);
        step(0, 16'h0, 0, 0, 1, 0, 0);
        step(0, 16'h0, 0, 0, 1, 0, 0);
        step(0, 16'h0, 0, 0, 0, 0, 0);
        chk("wr_done", 32'(done), 32'h1);

        // Wrap and INC_AR over LDAR priority
        step(0, 16'hFFFF, 1, 0, 0, 0, 0);
        step(0, 16'h0007, 1, 1, 0, 0, 0);
        chk("wrap", 32'(mem_addr), 32'h0000);

        // RD and WRM together: read only, MDR keeps memory data
        step(0, 16'h0040, 1, 0, 0, 0, 0);
        step(0, 16'hAAAA, 0, 0, 1, 1, 0);
        chk("conf_we", 32'(mem_we), 32'h0);
        step(0, 16'h0, 0, 0, 0, 0, 0);
        step(0, 16'h0, 0, 0, 0, 0, 0);
        step(0, 16'h0, 0, 0, 0, 0, 1);
        chk("conf_mdr", 32'(BOUT), 32'hBEEF);

        // Reset one cycle into a read, then a fresh read right after
        step(0, 16'h0, 0, 0, 1, 0, 0);
        step(1, 16'h0, 0, 0, 0, 0, 1);
        chk("midrst_mdr", 32'(BOUT), 32'h0);
        step(0, 16'h0, 0, 0, 1, 0, 0);
        chk("midrst_rd", 32'(mem_re), 32'h1);
        for (int i = 0; i < 4; i++) step(0, 16'h0, 0, 0, 0, 0, 0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            logic [DW-1:0] b;
            b = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            step($urandom_range(0, 63) == 0, b, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
